// File: rtl/alu_8bit.sv
// Registered 8-bit ALU: ADD/SUB/AND/OR/XOR/NOT/INC/SHR with carry, zero and overflow flags.
// Operands are captured on a rising edge with in_valid; results and flags appear one cycle later.
module alu_8bit #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       opcode,
  output logic             out_valid,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             zero,
  output logic             overflow
);

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_NOT = 3'b101,
    OP_INC = 3'b110,
    OP_SHR = 3'b111
  } op_e;

  logic [WIDTH-1:0] result_next;
  logic             carry_next;
  logic             overflow_next;
  op_e              op;

  assign op = op_e'(opcode);

  // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    result_next   = '0;
    carry_next    = 1'b0;
    overflow_next = 1'b0;
    unique case (op)
      OP_ADD: begin
        {carry_next, result_next} = {1'b0, A} + {1'b0, B};
        overflow_next = (A[WIDTH-1] == B[WIDTH-1]) && (result_next[WIDTH-1] != A[WIDTH-1]);
      end
      OP_SUB: begin
        // The 9-bit difference wraps into its top bit exactly when A < B unsigned.
        {carry_next, result_next} = {1'b0, A} - {1'b0, B};
        overflow_next = (A[WIDTH-1] != B[WIDTH-1]) && (result_next[WIDTH-1] != A[WIDTH-1]);
      end
      OP_AND: result_next = A & B;
      OP_OR:  result_next = A | B;
      OP_XOR: result_next = A ^ B;
      OP_NOT: result_next = ~A;
      OP_INC: begin
        {carry_next, result_next} = {1'b0, A} + (WIDTH + 1)'(1);
        overflow_next = !A[WIDTH-1] && result_next[WIDTH-1];
      end
      OP_SHR: begin
        result_next = {1'b0, A[WIDTH-1:1]};
        carry_next  = A[0];
      end
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      result    <= '0;
      carry     <= 1'b0;
      zero      <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        result   <= result_next;
        carry    <= carry_next;
        zero     <= (result_next == '0);
        overflow <= overflow_next;
      end
    end
  end

endmodule

// File: tb/tb_alu_8bit.sv
// Directed self-checking bench for alu_8bit: reset, every opcode, flag corner cases and handshake timing.
// Observed outputs are packed as {out_valid, result, carry, zero, overflow} and compared to hand-computed vectors.
module tb_alu_8bit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic [7:0] A;
  logic [7:0] B;
  logic [2:0] opcode;
  logic       out_valid;
  logic [7:0] result;
  logic       carry;
  logic       zero;
  logic       overflow;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    string      name;
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] op;
    logic [11:0] exp;
  } vec_t;

  alu_8bit dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .A        (A),
    .B        (B),
    .opcode   (opcode),
    .out_valid(out_valid),
    .result   (result),
    .carry    (carry),
    .zero     (zero),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  function automatic logic [11:0] pack_exp(input logic v, input logic [7:0] r,
                                           input logic c, input logic z, input logic o);
    return {v, r, c, z, o};
  endfunction

  function automatic logic [11:0] observed();
    return {out_valid, result, carry, zero, overflow};
  endfunction

  // Drive one operation at the falling edge, then settle just past the capturing rising edge.
  task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
    @(negedge clk);
    A = a; B = b; opcode = op; in_valid = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    A = 8'hA5; B = 8'h5A; opcode = 3'b001; in_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [11:0] got;
    rst_n = 1'b0; in_valid = 1'b0; A = '0; B = '0; opcode = '0;
    repeat (2) @(posedge clk);
    #1;
    got = observed();
    n_checks++;
    if (got !== 12'h000) begin
      n_fail++;
      $display("FAIL reset_initial: got %h expected %h", got, 12'h000);
    end
    @(negedge clk);
    rst_n = 1'b1;
    issue(8'hD7, 8'h41, 3'b000);
    // Assert reset mid-cycle while a new operation is presented; outputs must clear at once.
    @(negedge clk);
    A = 8'h7F; B = 8'h01; opcode = 3'b000; in_valid = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    got = observed();
    n_checks++;
    if (got !== 12'h000) begin
      n_fail++;
      $display("FAIL reset_async: got %h expected %h", got, 12'h000);
    end
    @(posedge clk);
    #1;
    got = observed();
    n_checks++;
    if (got !== 12'h000) begin
      n_fail++;
      $display("FAIL reset_held: got %h expected %h", got, 12'h000);
    end
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b1;
  endtask

  task automatic test_add();
    vec_t v[3];
    logic [11:0] got;
    v[0] = '{"add_d7_41", 8'hD7, 8'h41, 3'b000, pack_exp(1'b1, 8'h18, 1'b1, 1'b0, 1'b0)};
    v[1] = '{"add_7f_01", 8'h7F, 8'h01, 3'b000, pack_exp(1'b1, 8'h80, 1'b0, 1'b0, 1'b1)};
    v[2] = '{"add_80_80", 8'h80, 8'h80, 3'b000, pack_exp(1'b1, 8'h00, 1'b1, 1'b1, 1'b1)};
    foreach (v[i]) begin
      issue(v[i].a, v[i].b, v[i].op);
      got = observed();
      n_checks++;
      if (got !== v[i].exp) begin
        n_fail++;
        $display("FAIL %s: got {v,r,c,z,o}=%h expected %h", v[i].name, got, v[i].exp);
      end
    end
  endtask

  task automatic test_sub();
    vec_t v[4];
    logic [11:0] got;
    v[0] = '{"sub_37_01", 8'h37, 8'h01, 3'b001, pack_exp(1'b1, 8'h36, 1'b0, 1'b0, 1'b0)};
    v[1] = '{"sub_00_01", 8'h00, 8'h01, 3'b001, pack_exp(1'b1, 8'hFF, 1'b1, 1'b0, 1'b0)};
    v[2] = '{"sub_80_01", 8'h80, 8'h01, 3'b001, pack_exp(1'b1, 8'h7F, 1'b0, 1'b0, 1'b1)};
    v[3] = '{"sub_55_55", 8'h55, 8'h55, 3'b001, pack_exp(1'b1, 8'h00, 1'b0, 1'b1, 1'b0)};
    foreach (v[i]) begin
      issue(v[i].a, v[i].b, v[i].op);
      got = observed();
      n_checks++;
      if (got !== v[i].exp) begin
        n_fail++;
        $display("FAIL %s: got {v,r,c,z,o}=%h expected %h", v[i].name, got, v[i].exp);
      end
    end
  endtask

  task automatic test_logic();
    vec_t v[5];
    logic [11:0] got;
    v[0] = '{"and_6d_51", 8'h6D, 8'h51, 3'b010, pack_exp(1'b1, 8'h41, 1'b0, 1'b0, 1'b0)};
    v[1] = '{"or_6d_51",  8'h6D, 8'h51, 3'b011, pack_exp(1'b1, 8'h7D, 1'b0, 1'b0, 1'b0)};
    v[2] = '{"xor_6d_51", 8'h6D, 8'h51, 3'b100, pack_exp(1'b1, 8'h3C, 1'b0, 1'b0, 1'b0)};
    v[3] = '{"not_6d",    8'h6D, 8'h51, 3'b101, pack_exp(1'b1, 8'h92, 1'b0, 1'b0, 1'b0)};
    v[4] = '{"not_ff",    8'hFF, 8'h33, 3'b101, pack_exp(1'b1, 8'h00, 1'b0, 1'b1, 1'b0)};
    foreach (v[i]) begin
      issue(v[i].a, v[i].b, v[i].op);
      got = observed();
      n_checks++;
      if (got !== v[i].exp) begin
        n_fail++;
        $display("FAIL %s: got {v,r,c,z,o}=%h expected %h", v[i].name, got, v[i].exp);
      end
    end
  endtask

  task automatic test_inc();
    vec_t v[3];
    logic [11:0] got;
    v[0] = '{"inc_6d", 8'h6D, 8'hFF, 3'b110, pack_exp(1'b1, 8'h6E, 1'b0, 1'b0, 1'b0)};
    v[1] = '{"inc_ff", 8'hFF, 8'h00, 3'b110, pack_exp(1'b1, 8'h00, 1'b1, 1'b1, 1'b0)};
    v[2] = '{"inc_7f", 8'h7F, 8'h80, 3'b110, pack_exp(1'b1, 8'h80, 1'b0, 1'b0, 1'b1)};
    foreach (v[i]) begin
      issue(v[i].a, v[i].b, v[i].op);
      got = observed();
      n_checks++;
      if (got !== v[i].exp) begin
        n_fail++;
        $display("FAIL %s: got {v,r,c,z,o}=%h expected %h", v[i].name, got, v[i].exp);
      end
    end
  endtask

  task automatic test_shr();
    vec_t v[3];
    logic [11:0] got;
    v[0] = '{"shr_cf", 8'hCF, 8'h12, 3'b111, pack_exp(1'b1, 8'h67, 1'b1, 1'b0, 1'b0)};
    v[1] = '{"shr_01", 8'h01, 8'hFF, 3'b111, pack_exp(1'b1, 8'h00, 1'b1, 1'b1, 1'b0)};
    v[2] = '{"shr_80", 8'h80, 8'h00, 3'b111, pack_exp(1'b1, 8'h40, 1'b0, 1'b0, 1'b0)};
    foreach (v[i]) begin
      issue(v[i].a, v[i].b, v[i].op);
      got = observed();
      n_checks++;
      if (got !== v[i].exp) begin
        n_fail++;
        $display("FAIL %s: got {v,r,c,z,o}=%h expected %h", v[i].name, got, v[i].exp);
      end
    end
  endtask

  task automatic test_handshake();
    logic [11:0] got;
    logic [11:0] exp_hold;
    issue(8'hD7, 8'h41, 3'b000);
    got = observed();
    n_checks++;
    if (got !== pack_exp(1'b1, 8'h18, 1'b1, 1'b0, 1'b0)) begin
      n_fail++;
      $display("FAIL hs_issue: got %h expected %h", got, pack_exp(1'b1, 8'h18, 1'b1, 1'b0, 1'b0));
    end
    exp_hold = pack_exp(1'b0, 8'h18, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      idle_cycle();
      got = observed();
      n_checks++;
      if (got !== exp_hold) begin
        n_fail++;
        $display("FAIL hs_hold_%0d: got %h expected %h", i, got, exp_hold);
      end
    end
  endtask

  task automatic test_back_to_back();
    vec_t v[5];
    logic [11:0] got;
    v[0] = '{"b2b_add", 8'h10, 8'h20, 3'b000, pack_exp(1'b1, 8'h30, 1'b0, 1'b0, 1'b0)};
    v[1] = '{"b2b_sub", 8'h10, 8'h20, 3'b001, pack_exp(1'b1, 8'hF0, 1'b1, 1'b0, 1'b0)};
    v[2] = '{"b2b_xor", 8'hF0, 8'hF0, 3'b100, pack_exp(1'b1, 8'h00, 1'b0, 1'b1, 1'b0)};
    v[3] = '{"b2b_inc", 8'h41, 8'h00, 3'b110, pack_exp(1'b1, 8'h42, 1'b0, 1'b0, 1'b0)};
    v[4] = '{"b2b_shr", 8'h42, 8'h00, 3'b111, pack_exp(1'b1, 8'h21, 1'b0, 1'b0, 1'b0)};
    foreach (v[i]) begin
      issue(v[i].a, v[i].b, v[i].op);
      got = observed();
      n_checks++;
      if (got !== v[i].exp) begin
        n_fail++;
        $display("FAIL %s: got {v,r,c,z,o}=%h expected %h", v[i].name, got, v[i].exp);
      end
    end
    idle_cycle();
    got = observed();
    n_checks++;
    if (got !== pack_exp(1'b0, 8'h21, 1'b0, 1'b0, 1'b0)) begin
      n_fail++;
      $display("FAIL b2b_drop: got %h expected %h", got, pack_exp(1'b0, 8'h21, 1'b0, 1'b0, 1'b0));
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_logic();
    test_inc();
    test_shr();
    test_handshake();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
